// File: rtl/injection_arbiter_pkg.sv
// Shared constants, state encoding and width helpers for the injection arbiter.
// Stands in for the system-wide header: channel width, flits per packet, counter widths.
package injection_arbiter_pkg;

  localparam int CHANNEL_WIDTH    = 16;
  localparam int FLITS_PER_PACKET = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic int credit_cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/injection_arbiter_if.sv
// Requester/credit side of the injection port. master = requesters plus credit source,
// slave = the arbiter.
interface injection_arbiter_if
  import injection_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FLITS   = FLITS_PER_PACKET,
  parameter int CW      = CHANNEL_WIDTH,
  parameter int CREDITS = 2
) ();

  localparam int CCW = credit_cnt_w(CREDITS);

  logic [NUM_REQ-1:0]          req_in;
  logic [NUM_REQ*FLITS*CW-1:0] pkt_in;
  logic                        credit_in;
  logic [NUM_REQ-1:0]          grant_out;
  logic [CW-1:0]               channel_out;
  logic                        busy_out;
  logic [CCW-1:0]              credit_count_out;
  logic                        credit_error_out;

  modport master (
    output req_in, pkt_in, credit_in,
    input  grant_out, channel_out, busy_out, credit_count_out, credit_error_out
  );

  modport slave (
    input  req_in, pkt_in, credit_in,
    output grant_out, channel_out, busy_out, credit_count_out, credit_error_out
  );

endinterface

// File: rtl/injection_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
// Zero latency; vld_o low when no request is pending.
module injection_arbiter_rr_arbiter
  import injection_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

  assign vld_o = found;

endmodule

// File: rtl/injection_arbiter.sv
// Shares one router input among NUM_REQ requesters: round-robin grant, FLITS-flit serializer.
// Header appears one edge after req_in is sampled; grants stall while no downstream credit is held.
module injection_arbiter
  import injection_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CREDITS = 2,
  parameter int FLITS   = FLITS_PER_PACKET,
  parameter int CW      = CHANNEL_WIDTH
) (
  input logic           clk,
  input logic           reset,
  injection_arbiter_if.slave bus
);

  localparam int CCW = credit_cnt_w(CREDITS);
  localparam int IW  = idx_w(NUM_REQ);
  localparam int FW  = idx_w(FLITS);

  localparam logic [CCW-1:0] CREDIT_MAX = CCW'(CREDITS);
  localparam logic [FW-1:0]  LAST_FLIT  = FW'(FLITS - 1);

  typedef logic [FLITS-1:0][CW-1:0] pkt_t;

  pkt_t [NUM_REQ-1:0] pkt_arr;

  state_e             state_q;
  logic [FW-1:0]      cnt_q;
  pkt_t               pkt_q;
  logic [IW-1:0]      ptr_q;
  logic [CCW-1:0]     credit_q, credit_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [CW-1:0]      chan_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_vld;
  logic               issue;

  assign pkt_arr = bus.pkt_in;

  injection_arbiter_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req_i (bus.req_in),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  assign issue = (state_q == ST_IDLE) && win_vld && (credit_q != '0);

  // A return on the same edge as a header issue cancels out; a surplus return saturates.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (issue && !bus.credit_in) begin
      credit_d = credit_q - CCW'(1);
    end else if (!issue && bus.credit_in) begin
      if (credit_q == CREDIT_MAX) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + CCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pkt_q    <= '0;
      ptr_q    <= '0;
      credit_q <= CREDIT_MAX;
      err_q    <= 1'b0;
      grant_q  <= '0;
      chan_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
      grant_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            pkt_q   <= pkt_arr[win_idx];
            chan_q  <= pkt_arr[win_idx][0];
            grant_q <= win_oh;
            ptr_q   <= IW'((int'(win_idx) + 1) % NUM_REQ);
            busy_q  <= 1'b1;
            cnt_q   <= FW'(1);
            if (FLITS > 1) begin
              state_q <= ST_SEND;
            end
          end else begin
            chan_q <= '0;
            busy_q <= 1'b0;
          end
        end
        ST_SEND: begin
          // After the last flit is driven we fall back to IDLE so the next edge can issue back-to-back.
          chan_q <= pkt_q[cnt_q];
          busy_q <= 1'b1;
          cnt_q  <= cnt_q + FW'(1);
          if (cnt_q == LAST_FLIT) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant_out        = grant_q;
  assign bus.channel_out      = chan_q;
  assign bus.busy_out         = busy_q;
  assign bus.credit_count_out = credit_q;
  assign bus.credit_error_out = err_q;

endmodule
